// File: rtl/clock_generator.sv
// Programmable reference-clock divider: 50 % duty generated clock with a runtime
// half period, one-cycle rise/fall strobes and a 32-bit rising-edge counter.
module clock_generator #(
   parameter int unsigned HALF_PERIOD = 5,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] half_period_in,
   input  logic             half_period_load,
   output logic             clock,
   output logic             rise,
   output logic             fall,
   output logic [31:0]      cycle_count
);

   localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(HALF_PERIOD);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [CNT_W-1:0] half_q, half_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic             clock_q, clock_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [31:0]      count_q, count_d;
   logic             load_ok;
   logic             last_phase;

   // A zero half period would never terminate a phase, so such loads are dropped.
   assign load_ok    = half_period_load && (half_period_in != '0);
   assign last_phase = (phase_q == (half_q - ONE));

   always_comb begin
      half_d  = half_q;
      phase_d = phase_q;
      clock_d = clock_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      count_d = count_q;
      if (load_ok) begin
         half_d  = half_period_in;
         phase_d = '0;
      end else if (en) begin
         if (last_phase) begin
            phase_d = '0;
            clock_d = ~clock_q;
            rise_d  = ~clock_q;
            fall_d  = clock_q;
            if (!clock_q) begin
               count_d = count_q + 32'd1;
            end
         end else begin
            phase_d = phase_q + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         half_q  <= HALF_RST;
         phase_q <= '0;
         clock_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         count_q <= '0;
      end else begin
         half_q  <= half_d;
         phase_q <= phase_d;
         clock_q <= clock_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         count_q <= count_d;
      end
   end

   assign clock       = clock_q;
   assign rise        = rise_q;
   assign fall        = fall_q;
   assign cycle_count = count_q;

endmodule

// File: tb/tb_clock_generator.sv
// Directed and randomized bench for clock_generator; a countdown-based reference
// model tracks every cycle while directed steps check the documented edge timing.
module tb_clock_generator;

   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en = 1'b0;
   logic [CNT_W-1:0] half_period_in = '0;
   logic             half_period_load = 1'b0;
   logic             clock;
   logic             rise;
   logic             fall;
   logic [31:0]      cycle_count;

   int checks = 0;
   int failures = 0;
   int ecount = 0;

   // Reference model: cycles left before the next toggle, current level, rise total.
   int unsigned m_half;
   int unsigned m_left;
   logic        m_lvl;
   logic        m_rise;
   logic        m_fall;
   logic [31:0] m_rises;

   clock_generator dut (
      .clk              (clk),
      .rst              (rst),
      .en               (en),
      .half_period_in   (half_period_in),
      .half_period_load (half_period_load),
      .clock            (clock),
      .rise             (rise),
      .fall             (fall),
      .cycle_count      (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (rst) begin
         m_half  = 5;
         m_left  = 5;
         m_lvl   = 1'b0;
         m_rises = 0;
      end else if (half_period_load && half_period_in != 0) begin
         m_half = half_period_in;
         m_left = half_period_in;
      end else if (en) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_lvl  = ~m_lvl;
            m_left = m_half;
            m_rise = m_lvl;
            m_fall = ~m_lvl;
            if (m_lvl) m_rises = m_rises + 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      ecount++;
      chk("model_clock", {31'd0, clock}, {31'd0, m_lvl});
      chk("model_rise", {31'd0, rise}, {31'd0, m_rise});
      chk("model_fall", {31'd0, fall}, {31'd0, m_fall});
      chk("model_count", cycle_count, m_rises);
      chk("strobe_excl", {31'd0, rise & fall}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en = 1'b0;
      half_period_load = 1'b0;
      half_period_in = '0;
      tick();
      rst = 1'b0;
      ecount = 0;
   endtask

   function automatic logic exp_default_clk(input int e);
      return ((e / 5) % 2) == 1;
   endfunction

   initial begin
      // Reset state
      do_reset();
      chk("rst_clock", {31'd0, clock}, 32'd0);
      chk("rst_rise", {31'd0, rise}, 32'd0);
      chk("rst_fall", {31'd0, fall}, 32'd0);
      chk("rst_count", cycle_count, 32'd0);

      // Defaults: rise at 5,15,25, fall at 10,20
      en = 1'b1;
      for (int e = 1; e <= 25; e++) begin
         tick();
         chk("def_clock", {31'd0, clock}, {31'd0, exp_default_clk(e)});
         chk("def_rise", {31'd0, rise}, {31'd0, (e % 10) == 5});
         chk("def_fall", {31'd0, fall}, {31'd0, (e % 10) == 0});
      end
      chk("def_count25", cycle_count, 32'd3);

      // en low for edges 7..10 pushes the fall to edge 14
      do_reset();
      en = 1'b1;
      for (int e = 1; e <= 6; e++) tick();
      en = 1'b0;
      for (int e = 7; e <= 10; e++) begin
         tick();
         chk("hold_clock", {31'd0, clock}, 32'd1);
         chk("hold_strobe", {30'd0, rise, fall}, 32'd0);
      end
      en = 1'b1;
      for (int e = 11; e <= 13; e++) begin
         tick();
         chk("resume_clock", {31'd0, clock}, 32'd1);
      end
      tick();
      chk("resume_fall14", {30'd0, clock, fall}, 32'd1);

      // Load 2 at edge 3: rise 5, fall 7, rise 9
      do_reset();
      en = 1'b1;
      tick();
      tick();
      half_period_load = 1'b1;
      half_period_in = 16'd2;
      tick();
      chk("load2_hold", {30'd0, clock, rise}, 32'd0);
      half_period_load = 1'b0;
      tick();
      chk("load2_e4", {31'd0, clock}, 32'd0);
      tick();
      chk("load2_rise5", {30'd0, clock, rise}, 32'd3);
      tick();
      tick();
      chk("load2_fall7", {30'd0, clock, fall}, 32'd1);
      tick();
      tick();
      chk("load2_rise9", {30'd0, clock, rise}, 32'd3);
      chk("load2_count", cycle_count, 32'd2);

      // Load 0 at edge 3 is ignored: timing matches the default run
      do_reset();
      en = 1'b1;
      tick();
      tick();
      half_period_load = 1'b1;
      half_period_in = 16'd0;
      tick();
      half_period_load = 1'b0;
      chk("load0_e3", {31'd0, clock}, {31'd0, exp_default_clk(3)});
      for (int e = 4; e <= 20; e++) begin
         tick();
         chk("load0_clock", {31'd0, clock}, {31'd0, exp_default_clk(e)});
      end

      // Load 1: toggle every cycle
      do_reset();
      en = 1'b1;
      tick();
      tick();
      half_period_load = 1'b1;
      half_period_in = 16'd1;
      tick();
      half_period_load = 1'b0;
      for (int e = 4; e <= 11; e++) begin
         tick();
         chk("hp1_clock", {31'd0, clock}, {31'd0, (e % 2) == 0});
         chk("hp1_rise", {31'd0, rise}, {31'd0, (e % 2) == 0});
         chk("hp1_fall", {31'd0, fall}, {31'd0, (e % 2) == 1});
      end

      // Reset while clock=1 at phase 3 (edge 9)
      do_reset();
      en = 1'b1;
      for (int e = 1; e <= 8; e++) tick();
      chk("pre_rst_clock", {31'd0, clock}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ecount = 0;
      chk("midrst_clock", {31'd0, clock}, 32'd0);
      chk("midrst_fall", {31'd0, fall}, 32'd0);
      chk("midrst_count", cycle_count, 32'd0);
      for (int e = 1; e <= 4; e++) begin
         tick();
         chk("midrst_low", {31'd0, clock}, 32'd0);
      end
      tick();
      chk("midrst_rise5", {30'd0, clock, rise}, 32'd3);

      // Randomized run against the reference model
      do_reset();
      for (int i = 0; i < 800; i++) begin
         en = ($urandom_range(0, 9) != 0);
         half_period_load = ($urandom_range(0, 24) == 0);
         half_period_in = CNT_W'($urandom_range(0, 4));
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      half_period_load = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
